// File: rtl/prefix_sum_stage.sv
// Completion stage for the pipelined KGP prefix adder: delays a^b to match the
// prefix latency, merges it with the resolved carries and registers the flags.
module prefix_sum_stage #(
  parameter int WIDTH = 64,
  parameter int LAT   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] carry_kgp,
  output logic               out_valid,
  output logic [WIDTH-1:0]   sum,
  output logic               carry_out,
  output logic               overflow,
  output logic               zero,
  output logic [3:0]         inflight
);

  // vld_pipe[LAT-1:0] is the propagate delay line, vld_pipe[LAT] is out_valid
  logic [LAT:0]                 vld_pipe_q, vld_pipe_d;
  logic [LAT-1:0][WIDTH-1:0]    p_pipe_q, p_pipe_d;
  logic [WIDTH-1:0]             sum_q, sum_d;
  logic                         carry_out_q, carry_out_d;
  logic                         overflow_q, overflow_d;
  logic                         zero_q, zero_d;
  logic [3:0]                   inflight_q, inflight_d;
  logic [WIDTH:0]               c;
  logic                         tail_vld;
  logic [WIDTH-1:0]             tail_p;

  assign tail_vld = vld_pipe_q[LAT-1];
  assign tail_p   = p_pipe_q[LAT-1];

  // Only the 2'b11 pair encodes a resolved carry; no carry-in at bit 0
  always_comb begin
    c    = '0;
    c[0] = 1'b0;
    for (int i = 0; i < WIDTH; i++)
      c[i+1] = &carry_kgp[2*i+1 -: 2];
  end

  always_comb begin
    vld_pipe_d = {vld_pipe_q[LAT-1:0], in_valid};
    p_pipe_d    = p_pipe_q;
    p_pipe_d[0] = a ^ b;
    for (int i = 1; i < LAT; i++)
      p_pipe_d[i] = p_pipe_q[i-1];
  end

  // carry_kgp is only looked at when the tail holds a live operation
  always_comb begin
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    if (tail_vld) begin
      sum_d       = tail_p ^ c[WIDTH-1:0];
      carry_out_d = c[WIDTH];
      overflow_d  = c[WIDTH] ^ c[WIDTH-1];
      zero_d      = ~|(tail_p ^ c[WIDTH-1:0]);
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({in_valid, vld_pipe_q[LAT]})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q  <= '0;
      p_pipe_q    <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      inflight_q  <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      p_pipe_q    <= p_pipe_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      inflight_q  <= inflight_d;
    end
  end

  assign out_valid = vld_pipe_q[LAT];
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign inflight  = inflight_q;

endmodule

// File: tb/tb_prefix_sum_stage.sv
// Bench for prefix_sum_stage: behavioural prefix pipeline feeding carry_kgp,
// fixed vector table, corner sequences and a randomized scoreboard run.
module tb_prefix_sum_stage;
  localparam int WIDTH = 64;
  localparam int LAT   = 5;

  logic                clk;
  logic                reset;
  logic                in_valid;
  logic [WIDTH-1:0]    a, b;
  logic [2*WIDTH-1:0]  carry_kgp;
  logic                out_valid;
  logic [WIDTH-1:0]    sum;
  logic                carry_out, overflow, zero;
  logic [3:0]          inflight;

  prefix_sum_stage #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
    .carry_kgp(carry_kgp), .out_valid(out_valid), .sum(sum),
    .carry_out(carry_out), .overflow(overflow), .zero(zero),
    .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a, b, sum;
    logic        cout, ovf, zero;
  } vec_t;

  typedef struct {
    logic [63:0] sum;
    logic        cout, ovf, zero;
  } res_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t q[$];
  bit   hist[$];
  res_t last;
  int   max_if;

  // Stand-in for the real prefix pipeline: carries from plain addition, with
  // random non-11 encodings for "no carry" and X whenever nothing is live.
  bit   [LAT-1:0]      pp_v = '0;
  logic [2*WIDTH-1:0]  pp_c [LAT];

  function automatic logic [2*WIDTH-1:0] kgp_enc(logic [63:0] x, logic [63:0] y);
    logic [64:0] s;
    logic [64:0] cin;
    logic [2*WIDTH-1:0] r;
    s   = {1'b0, x} + {1'b0, y};
    cin = s ^ {1'b0, x ^ y};
    r   = '0;
    for (int i = 0; i < WIDTH; i++)
      r[2*i +: 2] = cin[i+1] ? 2'b11 : 2'($urandom_range(0, 2));
    return r;
  endfunction

  always @(posedge clk) begin
    pp_v     <= {pp_v[LAT-2:0], in_valid === 1'b1};
    pp_c[0]  <= (in_valid === 1'b1) ? kgp_enc(a, b) : 'x;
    for (int i = 1; i < LAT; i++) pp_c[i] <= pp_c[i-1];
  end
  assign carry_kgp = pp_v[LAT-1] ? pp_c[LAT-1] : 'x;

  always @(negedge clk)
    if (reset === 1'b0)
      assert (inflight <= 4'(LAT + 1))
        else $error("FAIL inflight_bound: got %0d limit %0d", inflight, LAT + 1);

  function automatic res_t ref_model(logic [63:0] x, logic [63:0] y);
    res_t r;
    logic [64:0] s;
    s      = {1'b0, x} + {1'b0, y};
    r.sum  = s[63:0];
    r.cout = s[64];
    r.ovf  = (x[63] == y[63]) && (s[63] != x[63]);
    r.zero = (s[63:0] == 64'd0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle against the scoreboard: order, exact bubble timing, hold, inflight
  task automatic run_cycle(input bit rst, input bit vld, input logic [63:0] av, input logic [63:0] bv);
    bit exp_ov;
    reset = rst; in_valid = vld; a = av; b = bv;
    if (rst) begin
      q.delete(); hist.delete();
      last = '{sum: 64'd0, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
    end else if (vld) q.push_back(ref_model(av, bv));
    hist.push_back(vld && !rst);
    tick();
    exp_ov = 1'b0;
    if (hist.size() == LAT + 1) exp_ov = hist.pop_front();
    chk("inflight", 64'(inflight), 64'(q.size()));
    if (int'(inflight) > max_if) max_if = int'(inflight);
    chk("no_x", 64'($isunknown({out_valid, sum, carry_out, overflow, zero, inflight})), 64'd0);
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    if (exp_ov && q.size() > 0) last = q.pop_front();
    chk("sum", sum, last.sum);
    chk("carry_out", 64'(carry_out), 64'(last.cout));
    chk("overflow", 64'(overflow), 64'(last.ovf));
    chk("zero", 64'(zero), 64'(last.zero));
  endtask

  task automatic single_op(input vec_t v);
    reset = 1'b0; in_valid = 1'b1; a = v.a; b = v.b;
    tick();
    chk("lat_inflight", 64'(inflight), 64'd1);
    in_valid = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom};
    for (int k = 2; k <= LAT; k++) begin
      tick();
      chk("lat_early_ov", 64'(out_valid), 64'd0);
      chk("lat_inflight", 64'(inflight), 64'd1);
    end
    tick();
    chk("vec_ov", 64'(out_valid), 64'd1);
    chk("vec_inflight", 64'(inflight), 64'd1);
    chk("vec_sum", sum, v.sum);
    chk("vec_cout", 64'(carry_out), 64'(v.cout));
    chk("vec_ovf", 64'(overflow), 64'(v.ovf));
    chk("vec_zero", 64'(zero), 64'(v.zero));
    tick();
    chk("vec_ov_after", 64'(out_valid), 64'd0);
    chk("vec_inflight_after", 64'(inflight), 64'd0);
    chk("vec_sum_hold", sum, v.sum);
  endtask

  initial begin
    vec_t tbl[8];
    bit   pat[5];
    int   launched, cycles;
    bit   vld;
    logic [63:0] ra, rb;

    tbl[0] = '{64'h5, 64'h3, 64'h8, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0};
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", sum, 64'd0);
    chk("rst_flags", {61'd0, carry_out, overflow, zero}, 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);

    foreach (tbl[i]) single_op(tbl[i]);

    // Back-to-back burst: eight in a row, inflight must peak at LAT+1
    run_cycle(1'b1, 1'b0, '0, '0);
    max_if = 0;
    for (int k = 1; k <= 8; k++) run_cycle(1'b0, 1'b1, 64'(k), 64'(k) * 64'h1_0000_0001);
    for (int k = 0; k < 8; k++) run_cycle(1'b0, 1'b0, '0, '0);
    chk("inflight_peak", 64'(max_if), 64'(LAT + 1));

    // Bubble pattern preserved exactly, sum holds in the gaps
    foreach (pat[i]) run_cycle(1'b0, pat[i], {$urandom, $urandom}, {$urandom, $urandom});
    for (int k = 0; k < 8; k++) run_cycle(1'b0, 1'b0, '0, '0);

    // Reset at the second edge after the first launch drops everything
    run_cycle(1'b0, 1'b1, 64'h11, 64'h22);
    run_cycle(1'b0, 1'b1, 64'h33, 64'h44);
    run_cycle(1'b1, 1'b1, 64'h55, 64'h66);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", sum, 64'd0);
    chk("midrst_flags", {61'd0, carry_out, overflow, zero}, 64'd0);
    chk("midrst_inflight", 64'(inflight), 64'd0);
    for (int k = 0; k < 10; k++) run_cycle(1'b0, 1'b0, '0, '0);
    run_cycle(1'b0, 1'b1, 64'h1234, 64'h4321);
    for (int k = 0; k < 8; k++) run_cycle(1'b0, 1'b0, '0, '0);

    // Randomized run with bubbles, biased towards carry-chain corners
    launched = 0; cycles = 0;
    while (launched < 10000 && cycles < 30000) begin
      vld = ($urandom_range(0, 3) != 0);
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: ra = 64'hFFFF_FFFF_FFFF_FFFF;
        1: begin ra = 64'h7FFF_FFFF_FFFF_FFFF; rb = 64'($urandom_range(0, 3)); end
        2: rb = ~ra + 64'($urandom_range(0, 1));
        3: begin ra[63] = 1'b1; rb[63] = 1'b1; end
        default: ;
      endcase
      run_cycle(1'b0, vld, ra, rb);
      if (vld) launched++;
      cycles++;
    end
    chk("random_budget", 64'(launched), 64'd10000);
    for (int k = 0; k < 8; k++) run_cycle(1'b0, 1'b0, '0, '0);
    chk("drain_inflight", 64'(inflight), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
